alu_cmd_issuer: RTL

Command-side front end for the pipelined `alu` block. It accepts operation commands (opcode plus two operands) over a valid/ready handshake and drives them into the ALU's operand and opcode inputs. It tracks each command through the ALU's fixed latency and captures the double-width result into a small result FIFO, which is presented downstream with a valid/ready handshake and a sequence tag. Backpressure is credit-based, so no ALU result is ever dropped. The block sits between a command source (CPU shim or test sequencer) and the `alu` instance in the top level.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_cmd_issuer_chk.sv | 40 ++++
 rtl/alu_result_fifo.sv | 94 +++++++++
 rtl/alu_cmd_issuer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU, its command issuer and the benches:
//   - 3-bit opcode encodings OP_ADD .. OP_RSHIFT
//   - tracking-entry struct {op, tag} that follows a command through the ALU
//   - small width helper for counters that must hold the value N itself
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_XOR    = 3'd2;
    localparam logic [2:0] OP_AND    = 3'd3;
    localparam logic [2:0] OP_OR     = 3'd4;
    localparam logic [2:0] OP_MULT   = 3'd5;
    localparam logic [2:0] OP_LSHIFT = 3'd6;
    localparam logic [2:0] OP_RSHIFT = 3'd7;

    // Tag width of the default build; the issuer itself is parameterised.
    localparam int unsigned TRK_TAG_W = 4;

    typedef struct packed {
        logic [2:0]           op;
        logic [TRK_TAG_W-1:0] tag;
    } track_entry_t;

    // Bits needed for a counter whose range is 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/alu_cmd_issuer_chk.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer_chk
// Assertion-only companion of alu_cmd_issuer. Flags a write into a full
// result FIFO that is not matched by a pop, and checks that credits always
// account for every in-flight and stored result.
// Ports (all inputs):
//   clk, rst_n   clock, asynchronous active-low reset
//   wr_en        FIFO write request
//   rd_en        FIFO pop (already qualified by not-empty)
//   full         FIFO full flag
//   trk_valid    valid bits of the tracking pipeline
//   credits      credit register
//   count        FIFO occupancy
// -----------------------------------------------------------------------------
module alu_cmd_issuer_chk #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TRK_DEPTH  = 2,
    parameter int unsigned CRED_W     = 3
) (
    input logic                          clk,
    input logic                          rst_n,
    input logic                          wr_en,
    input logic                          rd_en,
    input logic                          full,
    input logic [TRK_DEPTH-1:0]          trk_valid,
    input logic [CRED_W-1:0]             credits,
    input logic [$clog2(FIFO_DEPTH):0]   count
);

    no_fifo_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(wr_en && full && !rd_en)
    );

    credits_conserved: assert property (
        @(posedge clk) disable iff (!rst_n)
        (32'(credits) + 32'($countones(trk_valid)) + 32'(count)) == 32'(FIFO_DEPTH)
    );

endmodule

// File: rtl/alu_result_fifo.sv
// -----------------------------------------------------------------------------
// alu_result_fifo
// Parameterised first-word-fall-through synchronous FIFO. The head entry is
// visible on rd_data whenever empty=0; rd_en pops it. A write and a pop in
// the same cycle are legal at any occupancy (no bypass: a write to an empty
// FIFO becomes visible after the edge). Storage is cleared on reset so the
// head reads as zero while empty after reset.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   wr_en, wr_data     push one entry
//   rd_en              pop the head (ignored when empty)
//   rd_data            head entry
//   full, empty        occupancy flags
//   count              occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module alu_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;
    logic [AW:0]      count_nxt_s;
    logic             wr_fire_s;
    logic             rd_fire_s;

    assign empty     = (count_r == {(AW+1){1'b0}});
    assign full      = (count_r == (AW+1)'(DEPTH));
    assign rd_fire_s = rd_en && !empty;
    // A write into a full FIFO only lands if the head leaves on the same edge.
    assign wr_fire_s = wr_en && (!full || rd_fire_s);
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array: cleared on reset, written at the write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_fire_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Read/write pointers; power-of-two depth lets them wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_fire_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Next occupancy from the write/pop pair.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_fire_s, rd_fire_s})
            2'b10:   count_nxt_s = count_r + (AW+1)'(1);
            2'b01:   count_nxt_s = count_r - (AW+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else begin
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// -----------------------------------------------------------------------------
// alu_cmd_issuer
// Command front end of the pipelined alu block. Accepts {op, a, b} commands
// over valid/ready, registers them onto the ALU inputs, follows each one
// through the ALU latency with a {valid, op, tag} shift register and stores
// the ALU result in a FWFT result FIFO presented downstream with its opcode
// and sequence tag. Credits cover in-flight plus stored results, so a result
// leaving the ALU always has a FIFO slot.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op, cmd_a, cmd_b          opcode and operands
//   alu_a, alu_b, alu_op          registered operands/opcode to the ALU
//   alu_result                    double-width ALU result
//   rsp_valid/rsp_ready           response handshake
//   rsp_data, rsp_op, rsp_tag     result, its opcode, its sequence tag
// -----------------------------------------------------------------------------
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [DATA_WIDTH-1:0]     cmd_a,
    input  logic [DATA_WIDTH-1:0]     cmd_b,
    output logic [DATA_WIDTH-1:0]     alu_a,
    output logic [DATA_WIDTH-1:0]     alu_b,
    output logic [2:0]                alu_op,
    input  logic [2*DATA_WIDTH-1:0]   alu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [2*DATA_WIDTH-1:0]   rsp_data,
    output logic [2:0]                rsp_op,
    output logic [TAG_W-1:0]          rsp_tag
);

    localparam int unsigned RES_W     = 2 * DATA_WIDTH;
    localparam int unsigned ENT_W     = RES_W + 3 + TAG_W;
    // One stage for the operand register, then one per ALU edge.
    localparam int unsigned TRK_DEPTH = 1 + ALU_LATENCY;
    localparam int unsigned TRK_LAST  = TRK_DEPTH - 1;
    localparam int unsigned CRED_W    = cnt_w(FIFO_DEPTH);

    logic                     accept_s;
    logic                     pop_s;
    logic [CRED_W-1:0]        credits_r;
    logic [CRED_W-1:0]        credits_nxt_s;
    logic [TAG_W-1:0]         tag_r;
    logic [TRK_DEPTH-1:0]     trk_valid_r;
    logic [2:0]               trk_op_r  [TRK_DEPTH];
    logic [TAG_W-1:0]         trk_tag_r [TRK_DEPTH];
    logic [DATA_WIDTH-1:0]    alu_a_r;
    logic [DATA_WIDTH-1:0]    alu_b_r;
    logic [2:0]               alu_op_r;
    logic [ENT_W-1:0]         fifo_wdata_s;
    logic [ENT_W-1:0]         fifo_rdata_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic                     fifo_wr_s;
    logic [$clog2(FIFO_DEPTH):0] fifo_count_s;

    // cmd_ready looks only at the credit register, so a pop in this cycle
    // cannot re-open the command port until the next one.
    assign cmd_ready = (credits_r != {CRED_W{1'b0}});
    assign accept_s  = cmd_valid && cmd_ready;
    assign rsp_valid = !fifo_empty_s;
    assign pop_s     = rsp_valid && rsp_ready;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_op    = alu_op_r;

    // Operand/opcode registers toward the ALU; hold when nothing is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_r  <= '0;
            alu_b_r  <= '0;
            alu_op_r <= 3'd0;
        end else if (accept_s) begin
            alu_a_r  <= cmd_a;
            alu_b_r  <= cmd_b;
            alu_op_r <= cmd_op;
        end
    end

    // Sequence tag, assigned to each accepted command then advanced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r <= '0;
        end else if (accept_s) begin
            tag_r <= tag_r + TAG_W'(1);
        end
    end

    // Next credit count: accept spends one, pop returns one, both cancel.
    always_comb begin
        credits_nxt_s = credits_r;
        case ({accept_s, pop_s})
            2'b10:   credits_nxt_s = credits_r - CRED_W'(1);
            2'b01:   credits_nxt_s = credits_r + CRED_W'(1);
            default: credits_nxt_s = credits_r;
        endcase
    end

    // Credit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits_r <= CRED_W'(FIFO_DEPTH);
        end else begin
            credits_r <= credits_nxt_s;
        end
    end

    // Tracking pipeline: stage 0 lines up with alu_*, the last stage lines up
    // with the edge on which alu_result belongs to that command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid_r <= '0;
            for (int i = 0; i < int'(TRK_DEPTH); i++) begin
                trk_op_r[i]  <= 3'd0;
                trk_tag_r[i] <= '0;
            end
        end else begin
            trk_valid_r[0] <= accept_s;
            trk_op_r[0]    <= cmd_op;
            trk_tag_r[0]   <= tag_r;
            for (int i = 1; i < int'(TRK_DEPTH); i++) begin
                trk_valid_r[i] <= trk_valid_r[i-1];
                trk_op_r[i]    <= trk_op_r[i-1];
                trk_tag_r[i]   <= trk_tag_r[i-1];
            end
        end
    end

    assign fifo_wr_s    = trk_valid_r[TRK_LAST];
    assign fifo_wdata_s = {alu_result, trk_op_r[TRK_LAST], trk_tag_r[TRK_LAST]};

    alu_result_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_result_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (fifo_wr_s),
        .wr_data (fifo_wdata_s),
        .rd_en   (rsp_ready),
        .rd_data (fifo_rdata_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

    assign rsp_data = fifo_rdata_s[ENT_W-1 -: RES_W];
    assign rsp_op   = fifo_rdata_s[TAG_W +: 3];
    assign rsp_tag  = fifo_rdata_s[TAG_W-1:0];

    alu_cmd_issuer_chk #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .TRK_DEPTH  (TRK_DEPTH),
        .CRED_W     (CRED_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (fifo_wr_s),
        .rd_en     (pop_s),
        .full      (fifo_full_s),
        .trk_valid (trk_valid_r),
        .credits   (credits_r),
        .count     (fifo_count_s)
    );

endmodule
